// File: rtl/addn_pkg.sv
// Shared types and defaults for the addn_reduce multi-operand accumulator.
// Holds the controller state encoding and the default geometry.
package addn_pkg;

    localparam int unsigned ADDN_W     = 64;
    localparam int unsigned ADDN_N     = 7;
    localparam int unsigned ADDN_LANES = 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } addn_state_e;

    // Number of accumulate cycles needed for n operands, lanes at a time.
    function automatic int unsigned addn_groups(
        input int unsigned n,
        input int unsigned lanes
    );
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/addn_lane_adder.sv
// Combinational adder: accumulator plus LANES operands in one step.
// The sum is formed wide enough that no carry is lost across lanes.
module addn_lane_adder
    import addn_pkg::*;
#(
    parameter int unsigned W     = ADDN_W,
    parameter int unsigned LANES = ADDN_LANES
) (
    input  logic [W-1:0]       acc_i,
    input  logic [LANES*W-1:0] ops_i,
    output logic [W-1:0]       sum_o,
    output logic               carry_o
);

    localparam int unsigned XW = W + $clog2(LANES + 1);

    logic [XW-1:0] total;

    // Add every lane into an extended-width total.
    always_comb begin
        total = XW'(acc_i);
        for (int l = 0; l < LANES; l++) begin
            total = total + XW'(ops_i[l*W +: W]);
        end
    end

    assign sum_o   = total[W-1:0];
    assign carry_o = |total[XW-1:W];

endmodule

// File: rtl/addn_reduce.sv
// Sums N captured W-bit operands, LANES per cycle, with wrap or saturate.
// Operands are held in a zero-padded shift register drained low group first.
module addn_reduce
    import addn_pkg::*;
#(
    parameter int unsigned W     = ADDN_W,
    parameter int unsigned N     = ADDN_N,
    parameter int unsigned LANES = ADDN_LANES
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           r_enable,
    input  logic [N*W-1:0] init_vec,
    input  logic           mode,
    output logic           w_enable,
    output logic [W-1:0]   result,
    output logic           overflow,
    output logic           busy
);

    localparam int unsigned C  = addn_groups(N, LANES);
    localparam int unsigned CW = $clog2(C + 1);
    localparam int unsigned GW = LANES * W;
    localparam int unsigned PW = C * GW;

    addn_state_e   state_q, state_d;
    logic [PW-1:0] ops_q, ops_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  res_q, res_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  sum;
    logic          co;

    addn_lane_adder #(
        .W     (W),
        .LANES (LANES)
    ) u_lane_adder (
        .acc_i   (acc_q),
        .ops_i   (ops_q[GW-1:0]),
        .sum_o   (sum),
        .carry_o (co)
    );

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ops_q   <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: capture in IDLE, accumulate C groups, publish on the last.
    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (r_enable) begin
                    ops_d   = PW'(init_vec);
                    mode_d  = mode;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                ops_d   = ops_q >> GW;
                acc_d   = (mode_q && co) ? '1 : sum;
                carry_d = carry_q | co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(C - 1)) begin
                    res_d   = acc_d;
                    ovf_d   = carry_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign w_enable = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign result   = res_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_addn_reduce.sv
// Directed bench for addn_reduce: four instances cover lane counts,
// narrow-width wrap/saturate, async reset, back-to-back and ignored starts.
module tb_addn_reduce;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    logic         r_en64, mode64;
    logic [447:0] vec64;
    logic         wa, wb, wc, oa, ob, oc, ba, bb, bc;
    logic [63:0]  ra, rb, rc;

    logic         r_en8, mode8;
    logic [31:0]  vec8;
    logic         wd, od, bd;
    logic [7:0]   rd;

    int n_checks = 0;
    int n_errors = 0;

    addn_reduce #(.W(64), .N(7), .LANES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .r_enable(r_en64), .init_vec(vec64),
        .mode(mode64), .w_enable(wa), .result(ra), .overflow(oa), .busy(ba)
    );

    addn_reduce #(.W(64), .N(7), .LANES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .r_enable(r_en64), .init_vec(vec64),
        .mode(mode64), .w_enable(wb), .result(rb), .overflow(ob), .busy(bb)
    );

    addn_reduce #(.W(64), .N(7), .LANES(7)) u_c (
        .clk(clk), .rst_n(rst_n), .r_enable(r_en64), .init_vec(vec64),
        .mode(mode64), .w_enable(wc), .result(rc), .overflow(oc), .busy(bc)
    );

    addn_reduce #(.W(8), .N(4), .LANES(1)) u_d (
        .clk(clk), .rst_n(rst_n), .r_enable(r_en8), .init_vec(vec8),
        .mode(mode8), .w_enable(wd), .result(rd), .overflow(od), .busy(bd)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [447:0] junk64();
        logic [447:0] v;
        for (int i = 0; i < 7; i++) v[i*64 +: 64] = {$urandom, $urandom};
        return v;
    endfunction

    function automatic logic [447:0] ramp64(input int base);
        logic [447:0] v;
        for (int i = 0; i < 7; i++) v[i*64 +: 64] = 64'(base + i);
        return v;
    endfunction

    // One job on u_a (C=7), inputs scrambled right after capture.
    task automatic run_a(input string tag, input logic [447:0] v,
                         input logic [63:0] exp);
        int lat;
        int n;
        vec64 = v; mode64 = 1'b0; r_en64 = 1'b1;
        @(negedge clk);
        r_en64 = 1'b0; vec64 = junk64(); mode64 = 1'b1;
        lat = 0; n = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (wa) begin n++; if (lat == 0) lat = j; end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd7);
        chk({tag, "_pulses"}, 64'(n), 64'd1);
        chk({tag, "_res"}, ra, exp);
        chk({tag, "_ovf"}, 64'(oa), 64'd0);
    endtask

    // One job on u_d (W=8, N=4, C=4), inputs scrambled after capture.
    task automatic run_d(input string tag, input logic [31:0] v,
                         input logic m, input logic [7:0] er,
                         input logic eo);
        int lat;
        int n;
        vec8 = v; mode8 = m; r_en8 = 1'b1;
        @(negedge clk);
        r_en8 = 1'b0; vec8 = ~v; mode8 = ~m;
        lat = 0; n = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (wd) begin n++; if (lat == 0) lat = j; end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk({tag, "_pulses"}, 64'(n), 64'd1);
        chk({tag, "_res"}, 64'(rd), 64'(er));
        chk({tag, "_ovf"}, 64'(od), 64'(eo));
    endtask

    logic [447:0] vs [3];
    logic [63:0]  sums [3];
    logic [63:0]  base_sum;
    int la, lb, lc, na, nb, nc, pulses;

    initial begin
        r_en64 = 1'b0; mode64 = 1'b0; vec64 = '0;
        r_en8 = 1'b0; mode8 = 1'b0; vec8 = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_wen", 64'(wa), 64'd0);
        chk("rst_busy", 64'(ba), 64'd0);
        chk("rst_res", ra, 64'd0);
        chk("rst_ovf", 64'(oa), 64'd0);
        chk("rst_res8", 64'(rd), 64'd0);
        chk("rst_busy8", 64'(bd), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Same operand set through 1, 2 and 7 lanes.
        base_sum = 64'd123 + 64'd234 + 64'd345 + 64'd456
                 + 64'd567 + 64'd678 + 64'd789;
        vec64 = {64'd789, 64'd678, 64'd567, 64'd456,
                 64'd345, 64'd234, 64'd123};
        r_en64 = 1'b1;
        @(negedge clk);
        r_en64 = 1'b0; vec64 = junk64();
        chk("lanes_busy0", 64'(ba), 64'd1);
        la = 0; lb = 0; lc = 0; na = 0; nb = 0; nc = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (wa) begin na++; if (la == 0) la = j; end
            if (wb) begin nb++; if (lb == 0) lb = j; end
            if (wc) begin nc++; if (lc == 0) lc = j; end
        end
        chk("l1_lat", 64'(la), 64'd7);
        chk("l1_pulses", 64'(na), 64'd1);
        chk("l1_res", ra, base_sum);
        chk("l1_ovf", 64'(oa), 64'd0);
        chk("l2_lat", 64'(lb), 64'd4);
        chk("l2_pulses", 64'(nb), 64'd1);
        chk("l2_res", rb, base_sum);
        chk("l7_lat", 64'(lc), 64'd1);
        chk("l7_pulses", 64'(nc), 64'd1);
        chk("l7_res", rc, base_sum);
        chk("l7_ovf", 64'(oc), 64'd0);

        // Narrow width: wrap, saturate, no-overflow, all-zero cases.
        run_d("w8_wrap", {8'd0, 8'd0, 8'd100, 8'd200}, 1'b0, 8'd44, 1'b1);
        run_d("w8_sat", {8'd0, 8'd0, 8'd100, 8'd200}, 1'b1, 8'd255, 1'b1);
        run_d("w8_sat_ok", {8'd40, 8'd30, 8'd20, 8'd10}, 1'b1, 8'd100, 1'b0);
        run_d("w8_zero", 32'd0, 1'b0, 8'd0, 1'b0);
        run_d("w8_edge_w", {8'd0, 8'd0, 8'd1, 8'd255}, 1'b0, 8'd0, 1'b1);
        run_d("w8_edge_s", {8'd0, 8'd0, 8'd1, 8'd255}, 1'b1, 8'd255, 1'b1);
        run_d("w8_multi", 32'hFFFF_FFFF, 1'b0, 8'd252, 1'b1);

        // Reset mid-job: outputs clear at once, no pulse, next job normal.
        vec64 = ramp64(1); r_en64 = 1'b1;
        @(negedge clk);
        r_en64 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(wa), 64'd0);
        chk("mid_rst_busy", 64'(ba), 64'd0);
        chk("mid_rst_res", ra, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        na = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (wa) na++;
        end
        chk("mid_rst_nopulse", 64'(na), 64'd0);
        chk("mid_rst_res_hold", ra, 64'd0);
        run_a("after_rst", ramp64(1000), 64'd7021);

        // r_enable held high: three jobs, period 9, inputs churned in ACC.
        for (int m = 0; m < 3; m++) begin
            vs[m] = ramp64((m + 1) * 100);
            sums[m] = 64'((m + 1) * 700 + 21);
        end
        vec64 = vs[0]; r_en64 = 1'b1;
        pulses = 0;
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk);
            if (wa) begin
                chk("hold_pos", 64'(j % 9), 64'd7);
                chk("hold_res", ra, sums[pulses < 3 ? pulses : 0]);
                pulses++;
            end
            if (j == 19) r_en64 = 1'b0;
            vec64 = (j % 9 >= 4 && j / 9 < 2) ? vs[j / 9 + 1] : junk64();
        end
        chk("hold_count", 64'(pulses), 64'd3);

        // Starts requested in ACC and DONE are ignored.
        vec64 = vs[0]; r_en64 = 1'b1;
        @(negedge clk);
        r_en64 = 1'b0; vec64 = junk64();
        pulses = 0; la = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            chk("ign_busy", 64'(ba), (j <= 7) ? 64'd1 : 64'd0);
            if (wa) begin pulses++; la = j; end
            r_en64 = (j == 3 || j == 7);
        end
        chk("ign_pulses", 64'(pulses), 64'd1);
        chk("ign_pos", 64'(la), 64'd7);
        chk("ign_res", ra, sums[0]);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
